wb_sevenseg_mux: RTL and testbench

- Parametrised, Wishbone-attached multiplexed 7-segment display controller. Successor to the fixed 4-digit hex display.
- Adds configurable digit count, per-digit decimal points, per-digit blanking, global enable, 16-level PWM brightness and register readback.
- Sits on the 16-bit Wishbone peripheral bus and drives board segment/anode pins directly.
- Single clock domain: the scan runs on clk_i, with no separate display clock.

---
 rtl/wb_sevenseg_mux.sv | 201 ++++++++++++++++++++
 tb/tb_wb_sevenseg_mux.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_sevenseg_mux.sv
// Wishbone-attached multiplexed 7-segment display controller.
// Holds a 32-bit display value, per-digit dp/blank masks and a brightness/enable
// control word, and time-multiplexes DIGITS digits onto one shared segment bus.
// The scan runs directly on clk_i; each digit owns a slot of 2^SLOT_LOG2 cycles.
// The top four bits of the slot counter form a 16-step PWM phase that sets the
// brightness.
module wb_sevenseg_mux #(
    parameter int DIGITS         = 4,
    parameter int SLOT_LOG2      = 14,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [1:0]        wb_adr_i,
    input  logic [15:0]       wb_dat_i,
    output logic [15:0]       wb_dat_o,
    input  logic [1:0]        wb_sel_i,
    input  logic              wb_we_i,
    input  logic              wb_cyc_i,
    input  logic              wb_stb_i,
    output logic              wb_ack_o,
    output logic [7:0]        seg,
    output logic [DIGITS-1:0] an
);

    localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [7:0]        SEG_OFF = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
    localparam logic [DIGITS-1:0] AN_OFF  = AN_ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    // Register file
    logic [31:0] val_reg;
    logic [7:0]  dp_en_reg;
    logic [7:0]  blank_reg;
    logic [3:0]  bright_reg;
    logic        enable_reg;

    // Bus side
    logic        ack_reg;
    logic [15:0] dat_reg;
    logic        req;
    logic        wr_en;
    logic [15:0] rd_data;

    // Scan state and registered pin drivers
    logic [SLOT_LOG2-1:0] s_reg;
    logic [DW-1:0]        d_reg;
    logic [7:0]           seg_reg;
    logic [DIGITS-1:0]    an_reg;

    // Per-digit views selected by the current scan position
    logic [3:0]        nib [DIGITS];
    logic [DIGITS-1:0] onehot;
    logic [3:0]        cur_nib;
    logic              cur_dp;
    logic              cur_blank;
    logic [3:0]        phase;
    logic              lit;
    logic [7:0]        pattern;
    logic [7:0]        seg_next;
    logic [DIGITS-1:0] an_next;

    assign req   = wb_cyc_i & wb_stb_i;
    assign wr_en = req & wb_we_i & ~ack_reg;

    assign wb_ack_o = ack_reg;
    assign wb_dat_o = dat_reg;
    assign seg      = seg_reg;
    assign an       = an_reg;

    // Active-low pattern for one hex nibble, dp off
    function automatic logic [7:0] hex_to_seg(input logic [3:0] n);
        logic [7:0] p;
        case (n)
            4'h0: p = 8'hC0;
            4'h1: p = 8'hF9;
            4'h2: p = 8'hA4;
            4'h3: p = 8'hB0;
            4'h4: p = 8'h99;
            4'h5: p = 8'h92;
            4'h6: p = 8'h82;
            4'h7: p = 8'hF8;
            4'h8: p = 8'h80;
            4'h9: p = 8'h90;
            4'hA: p = 8'h88;
            4'hB: p = 8'h83;
            4'hC: p = 8'hC6;
            4'hD: p = 8'hA1;
            4'hE: p = 8'h86;
            default: p = 8'h8E;
        endcase
        return p;
    endfunction

    // Split the value into nibbles and decode the scan index into a one-hot select
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign nib[gi]    = val_reg[4*gi +: 4];
            assign onehot[gi] = (d_reg == DW'(gi));
        end
    endgenerate

    // Readback mux; unused CTRL bits read as zero
    always_comb begin
        rd_data = 16'h0000;
        case (wb_adr_i)
            2'd0: rd_data = val_reg[15:0];
            2'd1: rd_data = val_reg[31:16];
            2'd2: rd_data = {blank_reg, dp_en_reg};
            default: rd_data = {11'b0, enable_reg, bright_reg};
        endcase
    end

    // Bus handshake, readback capture and byte-lane register writes
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ack_reg    <= 1'b0;
            dat_reg    <= 16'h0000;
            val_reg    <= 32'h0000_0000;
            dp_en_reg  <= 8'h00;
            blank_reg  <= 8'h00;
            bright_reg <= 4'hF;
            enable_reg <= 1'b1;
        end else begin
            ack_reg <= req & ~ack_reg;
            if (req & ~ack_reg) begin
                dat_reg <= rd_data;
            end
            if (wr_en) begin
                case (wb_adr_i)
                    2'd0: begin
                        if (wb_sel_i[0]) val_reg[7:0]  <= wb_dat_i[7:0];
                        if (wb_sel_i[1]) val_reg[15:8] <= wb_dat_i[15:8];
                    end
                    2'd1: begin
                        if (wb_sel_i[0]) val_reg[23:16] <= wb_dat_i[7:0];
                        if (wb_sel_i[1]) val_reg[31:24] <= wb_dat_i[15:8];
                    end
                    2'd2: begin
                        if (wb_sel_i[0]) dp_en_reg <= wb_dat_i[7:0];
                        if (wb_sel_i[1]) blank_reg <= wb_dat_i[15:8];
                    end
                    default: begin
                        // Only bright and enable exist, both in the low lane
                        if (wb_sel_i[0]) begin
                            bright_reg <= wb_dat_i[3:0];
                            enable_reg <= wb_dat_i[4];
                        end
                    end
                endcase
            end
        end
    end

    // Slot counter and digit index; the index wraps explicitly so any DIGITS works
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s_reg <= '0;
            d_reg <= '0;
        end else begin
            s_reg <= s_reg + 1'b1;
            if (&s_reg) begin
                if (d_reg == DW'(DIGITS - 1)) begin
                    d_reg <= '0;
                end else begin
                    d_reg <= d_reg + 1'b1;
                end
            end
        end
    end

    // Select the current digit's nibble and mask bits, then gate by enable/blank/PWM
    always_comb begin
        cur_nib   = 4'h0;
        cur_dp    = |(onehot & dp_en_reg[DIGITS-1:0]);
        cur_blank = |(onehot & blank_reg[DIGITS-1:0]);
        for (int i = 0; i < DIGITS; i++) begin
            if (onehot[i]) cur_nib = nib[i];
        end
        phase   = s_reg[SLOT_LOG2-1 -: 4];
        lit     = enable_reg & ~cur_blank & (phase <= bright_reg);
        pattern = hex_to_seg(cur_nib);
        if (cur_dp) pattern[7] = 1'b0;
        if (!SEG_ACTIVE_LOW) pattern = ~pattern;
        seg_next = lit ? pattern : SEG_OFF;
        an_next  = lit ? (AN_ACTIVE_LOW ? ~onehot : onehot) : AN_OFF;
    end

    // Register the pin drivers so seg/an lag the scan state by exactly one cycle
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            seg_reg <= SEG_OFF;
            an_reg  <= AN_OFF;
        end else begin
            seg_reg <= seg_next;
            an_reg  <= an_next;
        end
    end

endmodule

// File: tb/tb_wb_sevenseg_mux.sv
// Self-checking bench for wb_sevenseg_mux: a 4-digit and a 3-digit instance,
// 16-cycle slots, active-low segments and anodes.
module tb_wb_sevenseg_mux;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  adr = 2'd0;
    logic [15:0] wdat = 16'h0000;
    logic [15:0] rdat;
    logic [1:0]  sel = 2'b00;
    logic        we = 1'b0;
    logic        cyc = 1'b0;
    logic        stb = 1'b0;
    logic        ack;
    logic [7:0]  seg;
    logic [3:0]  an;

    logic [15:0] rdat3;
    logic        ack3;
    logic [7:0]  seg3;
    logic [2:0]  an3;

    int n_checks = 0;
    int n_fail   = 0;
    int tc       = 0;   // edges since reset release; outputs show scan state tc-1

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) tc <= 0;
        else     tc <= tc + 1;
    end

    wb_sevenseg_mux #(.DIGITS(4), .SLOT_LOG2(4), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)) dut (
        .clk_i(clk), .rst_i(rst), .wb_adr_i(adr), .wb_dat_i(wdat), .wb_dat_o(rdat),
        .wb_sel_i(sel), .wb_we_i(we), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_ack_o(ack),
        .seg(seg), .an(an)
    );

    wb_sevenseg_mux #(.DIGITS(3), .SLOT_LOG2(4), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)) dut3 (
        .clk_i(clk), .rst_i(rst), .wb_adr_i(2'd0), .wb_dat_i(16'h0000), .wb_dat_o(rdat3),
        .wb_sel_i(2'b00), .wb_we_i(1'b0), .wb_cyc_i(1'b0), .wb_stb_i(1'b0), .wb_ack_o(ack3),
        .seg(seg3), .an(an3)
    );

    typedef struct packed {
        logic [1:0]  adr;
        logic [15:0] dat;
        logic [1:0]  sel;
        logic [15:0] exp_rd;
        logic [31:0] exp_segs;   // {d3,d2,d1,d0} when lit
        logic [3:0]  dark;       // digits expected blanked
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (tc=%0d)", name, act, exp, tc);
        end
    endtask

    task automatic wb_write(input logic [1:0] a, input logic [15:0] d, input logic [1:0] s);
        @(negedge clk);
        adr = a; wdat = d; sel = s; we = 1'b1; cyc = 1'b1; stb = 1'b1;
        check("wr_ack_before", 32'(ack), 32'd0);
        @(posedge clk); #1;
        check("wr_ack_rise", 32'(ack), 32'd1);
        @(posedge clk); #1;
        check("wr_ack_single", 32'(ack), 32'd0);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        $display("write adr=%0d dat=%h sel=%b", a, d, s);
    endtask

    task automatic wb_read(input logic [1:0] a, input logic [15:0] exp);
        @(negedge clk);
        adr = a; we = 1'b0; cyc = 1'b1; stb = 1'b1; sel = 2'b11;
        @(posedge clk); #1;
        check("rd_ack_rise", 32'(ack), 32'd1);
        check("rd_data", 32'(rdat), 32'(exp));
        @(posedge clk); #1;
        check("rd_ack_single", 32'(ack), 32'd0);
        cyc = 1'b0; stb = 1'b0;
        $display("read  adr=%0d dat=%h expected=%h", a, rdat, exp);
    endtask

    // Check every cycle of n against the expected scan of the 4-digit instance
    task automatic check_scan(input logic [31:0] segs, input logic [3:0] dark,
                              input logic [3:0] br, input logic en, input int n);
        int k, dd, ph;
        logic lit;
        logic [3:0] exp_an;
        logic [7:0] exp_seg;
        for (int c = 0; c < n; c++) begin
            @(posedge clk); #1;
            k   = tc - 1;
            dd  = (k / 16) % 4;
            ph  = k % 16;
            lit = en && !dark[dd] && (ph <= int'(br));
            exp_an  = lit ? ~(4'b0001 << dd) : 4'hF;
            exp_seg = lit ? segs[dd*8 +: 8] : 8'hFF;
            check("scan_an_seg", {20'd0, an, seg}, {20'd0, exp_an, exp_seg});
        end
        $display("scan  %0d cycles segs=%h dark=%b bright=%h en=%b", n, segs, dark, br, en);
    endtask

    task automatic check_scan3(input int n);
        int k, dd;
        logic [2:0] exp_an;
        for (int c = 0; c < n; c++) begin
            @(posedge clk); #1;
            k  = tc - 1;
            dd = (k / 16) % 3;
            exp_an = ~(3'b001 << dd);
            check("scan3_an_seg", {21'd0, an3, seg3}, {21'd0, exp_an, 8'hC0});
        end
        $display("scan3 %0d cycles", n);
    endtask

    initial begin
        bit found;
        vecs[0] = '{2'd0, 16'h1234, 2'b11, 16'h1234, 32'hF9A4B099, 4'b0000};
        vecs[1] = '{2'd1, 16'hABCD, 2'b11, 16'hABCD, 32'hF9A4B099, 4'b0000};
        vecs[2] = '{2'd2, 16'hFF05, 2'b01, 16'h0005, 32'hF924B019, 4'b0000};
        vecs[3] = '{2'd2, 16'h0200, 2'b10, 16'h0205, 32'hF924B019, 4'b0010};
        vecs[4] = '{2'd0, 16'hE0F9, 2'b01, 16'h12F9, 32'hF9248E10, 4'b0010};
        vecs[5] = '{2'd0, 16'h8C00, 2'b10, 16'h8CF9, 32'h80468E10, 4'b0010};
        vecs[6] = '{2'd2, 16'h0000, 2'b11, 16'h0000, 32'h80C68E90, 4'b0000};
        vecs[7] = '{2'd0, 16'h6B5A, 2'b11, 16'h6B5A, 32'h82839288, 4'b0000};
        vecs[8] = '{2'd0, 16'h07DE, 2'b11, 16'h07DE, 32'hC0F8A186, 4'b0000};
        vecs[9] = '{2'd1, 16'h5555, 2'b10, 16'h55CD, 32'hC0F8A186, 4'b0000};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_dat", 32'(rdat), 32'd0);
        check("rst_an", 32'(an), 32'hF);
        check("rst_seg", 32'(seg), 32'hFF);
        check("rst_an3", 32'(an3), 32'h7);
        check("rst_ack3", 32'(ack3), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Default scan, 3-digit scan, default readback
        check_scan(32'hC0C0C0C0, 4'b0000, 4'hF, 1'b1, 64);
        check_scan3(96);
        wb_read(2'd0, 16'h0000);
        wb_read(2'd1, 16'h0000);
        wb_read(2'd2, 16'h0000);
        wb_read(2'd3, 16'h001F);

        // Table-driven register writes with display checks
        for (int i = 0; i < 10; i++) begin
            wb_write(vecs[i].adr, vecs[i].dat, vecs[i].sel);
            wb_read(vecs[i].adr, vecs[i].exp_rd);
            check_scan(vecs[i].exp_segs, vecs[i].dark, 4'hF, 1'b1, 64);
        end

        // Brightness, enable and ignored CTRL bits
        wb_write(2'd3, 16'h0013, 2'b11);
        wb_read(2'd3, 16'h0013);
        check_scan(32'hC0F8A186, 4'b0000, 4'h3, 1'b1, 64);
        wb_write(2'd3, 16'h0003, 2'b11);
        wb_read(2'd3, 16'h0003);
        check_scan(32'hC0F8A186, 4'b0000, 4'h3, 1'b0, 64);
        wb_write(2'd3, 16'hFFF0, 2'b10);
        wb_read(2'd3, 16'h0003);
        wb_write(2'd3, 16'h0010, 2'b11);
        wb_read(2'd3, 16'h0010);
        check_scan(32'hC0F8A186, 4'b0000, 4'h0, 1'b1, 64);
        wb_write(2'd3, 16'hFFFF, 2'b11);
        wb_read(2'd3, 16'h001F);

        // Reset during digit 2 with a write strobe pending
        found = 1'b0;
        for (int c = 0; c < 200 && !found; c++) begin
            @(posedge clk); #1;
            if (((tc - 1) / 16) % 4 == 2) found = 1'b1;
        end
        check("wait_digit2", 32'(found), 32'd1);
        rst = 1'b1; adr = 2'd0; wdat = 16'hFFFF; sel = 2'b11; we = 1'b1; cyc = 1'b1; stb = 1'b1;
        @(posedge clk); #1;
        check("midrst_ack", 32'(ack), 32'd0);
        check("midrst_an", 32'(an), 32'hF);
        check("midrst_seg", 32'(seg), 32'hFF);
        check("midrst_dat", 32'(rdat), 32'd0);
        rst = 1'b0; we = 1'b0; cyc = 1'b0; stb = 1'b0;
        @(posedge clk); #1;
        check("resume_ack", 32'(ack), 32'd0);
        check("resume_an", 32'(an), 32'hE);
        check("resume_seg", 32'(seg), 32'hC0);
        check_scan(32'hC0C0C0C0, 4'b0000, 4'hF, 1'b1, 63);
        check_scan3(48);
        wb_read(2'd0, 16'h0000);
        wb_read(2'd1, 16'h0000);
        wb_read(2'd2, 16'h0000);
        wb_read(2'd3, 16'h001F);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
